// File: rtl/upcounter_pkg.sv
// Shared definitions for the modulo-N up counter controller: FSM encoding and
// default sizing constants.
package upcounter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_MOD      = 16;
  localparam int unsigned DEF_PRESCALE = 1;

endpackage

// File: rtl/dff.sv
// Single-bit D flip-flop with asynchronous active-low reset; the count
// register is built from a bank of these.
module dff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= 1'b0;
    else       q <= d;
  end

endmodule

// File: rtl/upcounter_nsl.sv
// Next-count logic for the modulo-N counter: load clamp, increment/wrap,
// one-shot hold and terminal-count detect. Purely combinational.
module upcounter_nsl
  import upcounter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MOD   = DEF_MOD
) (
  input  logic [WIDTH-1:0] count,
  input  logic             tick,
  input  logic             restart,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count_d,
  output logic             at_term,
  output logic             wrap_stop
);

  localparam logic [WIDTH:0]   MOD_X  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   LAST_X = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] LAST_W = WIDTH'(MOD - 1);

  logic [WIDTH:0] count_x;
  logic [WIDTH:0] load_x;
  logic [WIDTH:0] inc_x;

  always_comb begin
    count_x   = {1'b0, count};
    load_x    = {1'b0, load_val};
    inc_x     = count_x + (WIDTH+1)'(1);
    at_term   = (count_x == LAST_X);
    wrap_stop = tick && !restart && at_term && oneshot;
    count_d   = count;
    if (load) begin
      count_d = (load_x >= MOD_X) ? LAST_W : load_val;
    end else if (tick) begin
      // First tick after leaving DONE always restarts from zero.
      if (restart)      count_d = '0;
      else if (at_term) count_d = oneshot ? count : '0;
      else              count_d = WIDTH'(inc_x);
    end
  end

endmodule

// File: rtl/upcounter_ctrl.sv
// Run/stop controlled modulo-N up counter with prescaled ticks, terminal-count
// pulse and busy/done status; the count lives in a bank of dff cells.
module upcounter_ctrl
  import upcounter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned MOD      = DEF_MOD,
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned  PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             restart_q, restart_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick, at_term, wrap_stop;
  logic [WIDTH-1:0] count_d;

  // stop halts counting in the same cycle, so it also masks the tick.
  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST) && !load && !stop;

  upcounter_nsl #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_nsl (
    .count     (count),
    .tick      (tick),
    .restart   (restart_q),
    .load      (load),
    .load_val  (load_val),
    .oneshot   (oneshot),
    .count_d   (count_d),
    .at_term   (at_term),
    .wrap_stop (wrap_stop)
  );

  always_comb begin
    state_d   = state_q;
    restart_d = restart_q;
    if (tick || load) restart_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!stop && start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          restart_d = 1'b0;
        end else if (wrap_stop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d   = ST_RUN;
          restart_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load || tick || state_q != ST_RUN || state_d != ST_RUN) presc_d = '0;
    else                                                        presc_d = presc_q + PW'(1);

    tc_d   = tick && at_term;
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      restart_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      restart_q <= restart_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    dff u_dff (
      .clk  (clk),
      .rstn (rstn),
      .d    (count_d[i]),
      .q    (count[i])
    );
  end

  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/upcounter_ctrl.md
Name: upcounter_ctrl

Overview:
- Controlled modulo-N up counter that drives the D inputs of a bank of `dff` bit registers.
- Generates the next-state word, prescaled count ticks and run/stop sequencing, so it sits directly upstream of the flop stage.
- Exposes count, terminal-count pulse and busy/done status to the board top level, which drives LEDs.

Parameters:
- WIDTH, 4, counter width in bits.
- MOD, 16, count modulus; count runs 0..MOD-1; MOD must satisfy 2 <= MOD <= 2^WIDTH.
- PRESCALE, 1, clocks per count tick; 1 means a tick every clock; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  level, sampled each clock; begins counting.
- stop  in  1  level; halts counting.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- oneshot  in  1  0 = free-run wrap, 1 = stop after reaching MOD-1.
- count  out  WIDTH  current count, taken from the dff bank outputs.
- tc  out  1  one-clock pulse on the tick where count goes MOD-1 -> next.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rstn low, async): count=0, prescaler=0, state=IDLE, tc=0, busy=0, done=0. All are registered, so every output is glitch-free.
- FSM states and transitions:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> DONE when oneshot=1 and a tick occurs with count==MOD-1.
  - DONE -> RUN on start; count restarts at 0 on the first tick.
  - DONE -> IDLE on stop.
- Priority within one cycle: load > stop > start. start and stop asserted together means stop wins.
- Tick generation:
  - Prescaler counts 0..PRESCALE-1 only in RUN and clears on leaving RUN.
  - tick = RUN and prescaler==PRESCALE-1.
  - First tick occurs PRESCALE clocks after entering RUN.
- On a tick:
  - Free-run: count <= (count==MOD-1) ? 0 : count+1.
  - One-shot at MOD-1: count holds at MOD-1 and the FSM enters DONE.
- tc:
  - Registered, high for exactly one clock, in the cycle after the tick where count==MOD-1 (aligned with count showing 0 in free-run).
  - Asserted in one-shot mode as well.
- Load:
  - count <= (load_val >= MOD) ? MOD-1 : load_val on the next edge.
  - Prescaler clears; state is unchanged.
  - Load suppresses any tick in the same cycle; no tc is generated.
- Mode changes:
  - oneshot is sampled at the tick only; toggling it mid-run takes effect at the next wrap check.
  - In DONE with oneshot later cleared, the FSM stays in DONE until start or stop.
- count changes only on tick or load; IDLE and DONE hold count.
- Width rule: next-state arithmetic uses WIDTH+1 bits internally; no overflow beyond MOD-1 is ever stored.
- Reset mid-run: immediate return to reset values; no tc pulse.
- The flop stage is WIDTH instances of `dff` sharing clk/rstn. All other registers (state, prescaler, tc, busy, done) use the same async active-low reset.

Decomposition:
- Shared package upcounter_pkg: FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and default WIDTH/MOD/PRESCALE constants.
- One natural sub-module, upcounter_nsl: combinational next-count and wrap/terminal detect, taking count, tick, load, load_val and oneshot. Its output feeds the `dff` bank's d inputs.
- Prescaler and FSM stay in upcounter_ctrl.

Test Plan:
- Reset then free-run: WIDTH=4, MOD=10, PRESCALE=1, pulse start. Required: count goes 0,1,…,9,0; tc is high exactly one clock when count shows 0 after 9; busy=1 throughout.
- One-shot: MOD=10, oneshot=1, start. Required: count reaches 9 and holds; done=1 and busy=0 from the next clock; one tc pulse. A second start restarts at 0 and sets busy=1.
- Prescale: PRESCALE=3, MOD=16, start. Required: count increments every 3rd clock; first increment is 3 clocks after busy rises; stop freezes count and clears the prescaler.
- Load and clamp: in RUN, load with load_val=5 gives count 5 next clock with no tick that cycle. With MOD=10, load_val=12 gives count 9.
- Simultaneous events: start and stop together in IDLE keeps IDLE. load with stop in RUN gives count=load_val and state IDLE. start during DONE with oneshot=0 resumes free-run from 0.
- Async reset mid-run: rstn low at count=7, between clock edges. Required: count=0, tc=0, busy=0, done=0 immediately; state IDLE after rstn rises with no spurious tick.
